// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-cache request/response bus between the fetch stage and the I-cache.
interface fetch_stage_if;
  logic        I_MEM_REQ;
  logic [31:0] I_MEM_ADDR;
  logic        I_MEM_READY;
  logic [31:0] I_MEM_DI;
  modport master(output I_MEM_REQ, I_MEM_ADDR, input I_MEM_READY, I_MEM_DI);
  modport slave(input I_MEM_REQ, I_MEM_ADDR, output I_MEM_READY, I_MEM_DI);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: RV32 instruction fetch, owns the PC, talks to the I-cache, fills the FD pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic          CLK,
  input  logic          RSTn,
  fetch_stage_if.master imem,
  input  logic          STALL,
  input  logic          REDIRECT,
  input  logic [31:0]   REDIRECT_PC,
  output logic [31:0]   FD_IR,
  output logic [31:0]   FD_PC,
  output logic          FD_VALID
);
  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;
  state_t state, state_n;
  logic run, req, rdy, done, fv_n;
  logic [31:0] pc, pc_n, addr, addr_n, buf_q, buf_n, ir_n, fpc_n, tgt;
  assign req = run && state != HOLD;
  assign rdy = run && imem.I_MEM_READY;
  assign imem.I_MEM_REQ = req;
  assign imem.I_MEM_ADDR = addr;
  assign tgt = REDIRECT_PC & 32'hFFFF_FFFC;
  // a redirect can retarget ADDR only when no request is left in flight
  assign done = !req || rdy;
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state <= FETCH;
      run <= 1'b0;
      pc <= RESET_PC;
      addr <= RESET_PC;
      buf_q <= '0;
      FD_IR <= NOP_INSN;
      FD_PC <= '0;
      FD_VALID <= 1'b0;
    end else begin
      state <= state_n;
      run <= 1'b1;
      pc <= pc_n;
      addr <= addr_n;
      buf_q <= buf_n;
      FD_IR <= ir_n;
      FD_PC <= fpc_n;
      FD_VALID <= fv_n;
    end
  end
  always_comb begin
    state_n = state;
    pc_n = pc;
    addr_n = addr;
    buf_n = buf_q;
    ir_n = FD_IR;
    fpc_n = FD_PC;
    fv_n = FD_VALID;
    if (REDIRECT) begin
      ir_n = NOP_INSN;
      fv_n = 1'b0;
      pc_n = tgt;
      addr_n = done ? tgt : addr;
      state_n = done ? FETCH : DROP;
    end else begin
      case (state)
        FETCH: begin
          if (rdy && !STALL) begin
            ir_n = imem.I_MEM_DI;
            fpc_n = addr;
            fv_n = 1'b1;
            pc_n = addr + 32'd4;
            addr_n = addr + 32'd4;
          end else if (rdy) begin
            buf_n = imem.I_MEM_DI;
            state_n = HOLD;
          end else if (!STALL) begin
            ir_n = NOP_INSN;
            fv_n = 1'b0;
          end
        end
        HOLD: begin
          if (!STALL) begin
            ir_n = buf_q;
            fpc_n = addr;
            fv_n = 1'b1;
            pc_n = addr + 32'd4;
            addr_n = addr + 32'd4;
            state_n = FETCH;
          end
        end
        DROP: begin
          addr_n = rdy ? pc : addr;
          state_n = rdy ? FETCH : DROP;
          ir_n = STALL ? FD_IR : NOP_INSN;
          fv_n = STALL && FD_VALID;
        end
        default: state_n = FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed test-plan scenarios plus randomized run against a transaction-level model.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic CLK = 1'b0;
  logic rst_n = 1'b0, stall = 1'b0, redirect = 1'b0;
  logic [31:0] rpc = '0;
  logic [31:0] ir, fpc;
  logic fv;
  int checks = 0, failures = 0;
  fetch_stage_if bus();
  fetch_stage dut (
    .CLK(CLK), .RSTn(rst_n), .imem(bus.master), .STALL(stall), .REDIRECT(redirect),
    .REDIRECT_PC(rpc), .FD_IR(ir), .FD_PC(fpc), .FD_VALID(fv)
  );
  always #5 CLK = ~CLK;
  logic m_live = 0, m_held = 0, m_stale = 0, m_fv = 0;
  logic [31:0] m_pc = 0, m_addr = 0, m_hword = 0, m_ir = NOP, m_fpc = 0;
  task automatic model_step();
    logic req, got;
    req = m_live && !m_held;
    got = req && bus.I_MEM_READY;
    if (!rst_n) begin
      m_live = 0; m_held = 0; m_stale = 0; m_pc = 0; m_addr = 0;
      m_hword = 0; m_ir = NOP; m_fpc = 0; m_fv = 0;
    end else begin
      if (redirect) begin
        m_ir = NOP; m_fv = 0; m_pc = rpc & ~32'd3; m_held = 0;
        if (!req || got) begin m_addr = m_pc; m_stale = 0; end else m_stale = 1;
      end else if (m_held) begin
        if (!stall) begin
          m_ir = m_hword; m_fpc = m_addr; m_fv = 1; m_addr += 4; m_pc = m_addr; m_held = 0;
        end
      end else if (got && m_stale) begin
        m_stale = 0; m_addr = m_pc;
        if (!stall) begin m_ir = NOP; m_fv = 0; end
      end else if (got) begin
        if (stall) begin m_held = 1; m_hword = bus.I_MEM_DI; end
        else begin m_ir = bus.I_MEM_DI; m_fpc = m_addr; m_fv = 1; m_addr += 4; m_pc = m_addr; end
      end else if (!stall) begin
        m_ir = NOP; m_fv = 0;
      end
      m_live = 1;
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
    model_step();
  endtask
  task automatic test_reset();
    rst_n = 0; stall = 0; redirect = 0; bus.I_MEM_READY = 1; bus.I_MEM_DI = 32'hFFFF_FFFF;
    tick(); tick();
    checks++;
    if ({bus.I_MEM_REQ, bus.I_MEM_ADDR} !== {1'b0, 32'h0}) begin
      failures++; $display("FAIL reset_bus got req=%b addr=%h want req=0 addr=00000000", bus.I_MEM_REQ, bus.I_MEM_ADDR);
    end
    checks++;
    if ({ir, fpc, fv} !== {NOP, 32'h0, 1'b0}) begin
      failures++; $display("FAIL reset_fd got ir=%h pc=%h v=%b want 00000013 00000000 0", ir, fpc, fv);
    end
  endtask
  task automatic test_stream();
    logic [31:0] a;
    rst_n = 1; bus.I_MEM_READY = 1;
    tick();
    checks++;
    if ({bus.I_MEM_REQ, bus.I_MEM_ADDR, fv, ir} !== {1'b1, 32'h0, 1'b0, NOP}) begin
      failures++; $display("FAIL stream_first got req=%b addr=%h v=%b ir=%h want 1 00000000 0 00000013", bus.I_MEM_REQ, bus.I_MEM_ADDR, fv, ir);
    end
    for (int k = 0; k < 4; k++) begin
      a = 32'(k * 4);
      bus.I_MEM_DI = 32'hA000_0000 | a;
      tick();
      checks++;
      if ({fpc, ir, fv, bus.I_MEM_ADDR} !== {a, 32'hA000_0000 | a, 1'b1, a + 32'd4}) begin
        failures++; $display("FAIL stream_%0d got pc=%h ir=%h v=%b addr=%h want pc=%h", k, fpc, ir, fv, bus.I_MEM_ADDR, a);
      end
    end
  endtask
  task automatic test_miss();
    bus.I_MEM_READY = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({bus.I_MEM_REQ, bus.I_MEM_ADDR, ir, fv} !== {1'b1, 32'h10, NOP, 1'b0}) begin
        failures++; $display("FAIL miss_bubble_%0d got req=%b addr=%h ir=%h v=%b want 1 00000010 00000013 0", k, bus.I_MEM_REQ, bus.I_MEM_ADDR, ir, fv);
      end
    end
    bus.I_MEM_READY = 1; bus.I_MEM_DI = 32'h1111_0010;
    tick();
    checks++;
    if ({fpc, ir, fv, bus.I_MEM_ADDR} !== {32'h10, 32'h1111_0010, 1'b1, 32'h14}) begin
      failures++; $display("FAIL miss_return got pc=%h ir=%h v=%b addr=%h want 00000010 11110010 1 00000014", fpc, ir, fv, bus.I_MEM_ADDR);
    end
  endtask
  task automatic test_stall_hold();
    bus.I_MEM_READY = 1;
    for (logic [31:0] a = 32'h14; a < 32'h20; a += 4) begin
      bus.I_MEM_DI = 32'hB000_0000 | a;
      tick();
    end
    stall = 1; bus.I_MEM_DI = 32'hDEAD_BEEF;
    for (int k = 0; k < 2; k++) begin
      tick();
      bus.I_MEM_READY = 0;
      checks++;
      if ({bus.I_MEM_REQ, fpc, ir, fv} !== {1'b0, 32'h1C, 32'hB000_001C, 1'b1}) begin
        failures++; $display("FAIL stall_hold_%0d got req=%b pc=%h ir=%h v=%b want 0 0000001c b000001c 1", k, bus.I_MEM_REQ, fpc, ir, fv);
      end
    end
    stall = 0;
    tick();
    checks++;
    if ({bus.I_MEM_REQ, fpc, ir, fv, bus.I_MEM_ADDR} !== {1'b1, 32'h20, 32'hDEAD_BEEF, 1'b1, 32'h24}) begin
      failures++; $display("FAIL stall_release got req=%b pc=%h ir=%h v=%b addr=%h want 1 00000020 deadbeef 1 00000024", bus.I_MEM_REQ, fpc, ir, fv, bus.I_MEM_ADDR);
    end
  endtask
  task automatic test_redirect_drop();
    bus.I_MEM_READY = 1;
    for (logic [31:0] a = 32'h24; a < 32'h30; a += 4) begin
      bus.I_MEM_DI = 32'hC000_0000 | a;
      tick();
    end
    bus.I_MEM_READY = 0; redirect = 1; rpc = 32'h0000_0103;
    tick();
    redirect = 0;
    checks++;
    if ({bus.I_MEM_REQ, bus.I_MEM_ADDR, ir, fv} !== {1'b1, 32'h30, NOP, 1'b0}) begin
      failures++; $display("FAIL drop_enter got req=%b addr=%h ir=%h v=%b want 1 00000030 00000013 0", bus.I_MEM_REQ, bus.I_MEM_ADDR, ir, fv);
    end
    tick();
    checks++;
    if ({bus.I_MEM_ADDR, fv} !== {32'h30, 1'b0}) begin
      failures++; $display("FAIL drop_wait got addr=%h v=%b want 00000030 0", bus.I_MEM_ADDR, fv);
    end
    bus.I_MEM_READY = 1; bus.I_MEM_DI = 32'hBAD0_0030;
    tick();
    checks++;
    if ({bus.I_MEM_REQ, bus.I_MEM_ADDR, ir, fv} !== {1'b1, 32'h100, NOP, 1'b0}) begin
      failures++; $display("FAIL drop_discard got req=%b addr=%h ir=%h v=%b want 1 00000100 00000013 0", bus.I_MEM_REQ, bus.I_MEM_ADDR, ir, fv);
    end
    bus.I_MEM_DI = 32'h0010_0100;
    tick();
    checks++;
    if ({fpc, ir, fv, bus.I_MEM_ADDR} !== {32'h100, 32'h0010_0100, 1'b1, 32'h104}) begin
      failures++; $display("FAIL redirect_target got pc=%h ir=%h v=%b addr=%h want 00000100 00100100 1 00000104", fpc, ir, fv, bus.I_MEM_ADDR);
    end
  endtask
  task automatic test_hold_redirect_wrap();
    stall = 1; bus.I_MEM_READY = 1; bus.I_MEM_DI = 32'h5555_0104;
    tick();
    bus.I_MEM_READY = 0; redirect = 1; rpc = 32'hFFFF_FFFC;
    tick();
    redirect = 0;
    checks++;
    if ({bus.I_MEM_REQ, bus.I_MEM_ADDR, ir, fv} !== {1'b1, 32'hFFFF_FFFC, NOP, 1'b0}) begin
      failures++; $display("FAIL hold_redirect got req=%b addr=%h ir=%h v=%b want 1 fffffffc 00000013 0", bus.I_MEM_REQ, bus.I_MEM_ADDR, ir, fv);
    end
    stall = 0; bus.I_MEM_READY = 1; bus.I_MEM_DI = 32'hCAFE_FFFC;
    tick();
    checks++;
    if ({fpc, ir, fv, bus.I_MEM_ADDR} !== {32'hFFFF_FFFC, 32'hCAFE_FFFC, 1'b1, 32'h0}) begin
      failures++; $display("FAIL pc_wrap got pc=%h ir=%h v=%b addr=%h want fffffffc cafefffc 1 00000000", fpc, ir, fv, bus.I_MEM_ADDR);
    end
  endtask
  task automatic test_reset_mid_miss();
    bus.I_MEM_READY = 0;
    tick();
    rst_n = 0; bus.I_MEM_READY = 1; bus.I_MEM_DI = 32'h0000_0077;
    tick();
    checks++;
    if ({bus.I_MEM_REQ, bus.I_MEM_ADDR, ir, fpc, fv} !== {1'b0, 32'h0, NOP, 32'h0, 1'b0}) begin
      failures++; $display("FAIL reset_mid_miss got req=%b addr=%h ir=%h pc=%h v=%b want 0 0 00000013 0 0", bus.I_MEM_REQ, bus.I_MEM_ADDR, ir, fpc, fv);
    end
    rst_n = 1;
    tick();
    checks++;
    if ({bus.I_MEM_REQ, fv} !== {1'b1, 1'b0}) begin
      failures++; $display("FAIL late_ready_ignored got req=%b v=%b want 1 0", bus.I_MEM_REQ, fv);
    end
    bus.I_MEM_DI = 32'hE000_0000;
    tick();
    checks++;
    if ({fpc, ir, fv} !== {32'h0, 32'hE000_0000, 1'b1}) begin
      failures++; $display("FAIL restart_fetch got pc=%h ir=%h v=%b want 00000000 e0000000 1", fpc, ir, fv);
    end
  endtask
  task automatic test_random(int n);
    for (int i = 0; i < n; i++) begin
      rst_n = ($urandom % 60) != 0;
      stall = ($urandom % 4) == 0;
      redirect = ($urandom % 8) == 0;
      rpc = ($urandom % 5 == 0) ? 32'hFFFF_FFFD : $urandom;
      bus.I_MEM_READY = m_live && !m_held && ($urandom % 3 != 0);
      bus.I_MEM_DI = (m_addr * 32'h9E37_79B1) ^ 32'h0123_4567;
      tick();
      checks++;
      if ({bus.I_MEM_REQ, bus.I_MEM_ADDR, ir, fpc, fv} !== {m_live && !m_held, m_addr, m_ir, m_fpc, m_fv}) begin
        failures++;
        $display("FAIL random_%0d got req=%b addr=%h ir=%h pc=%h v=%b want req=%b addr=%h ir=%h pc=%h v=%b",
                 i, bus.I_MEM_REQ, bus.I_MEM_ADDR, ir, fpc, fv, m_live && !m_held, m_addr, m_ir, m_fpc, m_fv);
      end
    end
  endtask
  initial begin
    bus.I_MEM_READY = 0;
    bus.I_MEM_DI = '0;
    test_reset();
    test_stream();
    test_miss();
    test_stall_hold();
    test_redirect_drop();
    test_hold_redirect_wrap();
    test_reset_mid_miss();
    test_random(4000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined RV32 core. It owns the PC and issues fetch requests to the instruction cache, which may take several cycles on a miss. It latches returned instructions into the fetch/decode pipeline register (FD_IR, FD_PC) consumed by the decode/control stage. It handles hazard-unit stalls and control-flow redirects from execute, and inserts NOP bubbles when no valid instruction is available.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSN, 32'h0000_0013, instruction placed in FD_IR for bubbles and flushes (addi x0,x0,0).

- CLK  input  1  clock; all state updates on rising edge.
- RSTn  input  1  reset, synchronous, active-low.
- I_MEM_REQ  output  1  fetch request to I-cache.
- I_MEM_ADDR  output  32  fetch address; stable while I_MEM_REQ=1 and I_MEM_READY=0.
- I_MEM_READY  input  1  I-cache response valid for the current request this cycle.
- I_MEM_DI  input  32  instruction word, valid when I_MEM_READY=1.
- STALL  input  1  hazard unit: hold FD register contents.
- REDIRECT  input  1  execute stage: taken branch/JAL/JALR; flush and refetch.
- REDIRECT_PC  input  32  redirect target; bits [1:0] ignored (treated as 0).
- FD_IR  output  32  fetched instruction to decode.
- FD_PC  output  32  PC of FD_IR.
- FD_VALID  output  1  FD_IR holds a real instruction (0 = bubble).

## Operation
- Registers: PC (next address to fetch), ADDR (address of outstanding request), BUF (skid buffer, 32b), state ∈ {FETCH, HOLD, DROP}.
- Reset (RSTn=0 at edge): state=FETCH, PC=ADDR=RESET_PC, FD_IR=NOP_INSN, FD_PC=0, FD_VALID=0, BUF=0. I_MEM_REQ=0 during reset cycle, then 1 from the first cycle after reset. Reset overrides everything, including a pending request; any late READY is ignored.
- I-cache protocol: once REQ is asserted, it stays high with constant ADDR until READY is sampled high. A request is never abandoned. READY may be high in the same cycle REQ first rises (hit).
- I_MEM_REQ = 1 in FETCH and DROP, 0 in HOLD. I_MEM_ADDR = ADDR.
- FETCH, priority order:
  - REDIRECT: FD_IR←NOP_INSN, FD_VALID←0, PC←REDIRECT_PC. If READY: ADDR←REDIRECT_PC, stay FETCH, response discarded. Else go DROP, ADDR unchanged.
  - READY & !STALL: FD_IR←I_MEM_DI, FD_PC←ADDR, FD_VALID←1, PC←ADDR+4, ADDR←ADDR+4.
  - READY & STALL: BUF←I_MEM_DI, go HOLD. FD unchanged.
  - !READY & !STALL: FD_IR←NOP_INSN, FD_VALID←0 (bubble). FD_PC unchanged.
  - !READY & STALL: FD unchanged.
- HOLD:
  - REDIRECT: discard BUF, flush FD as above, PC←ADDR←REDIRECT_PC, go FETCH.
  - !STALL: FD_IR←BUF, FD_PC←ADDR, FD_VALID←1, PC←ADDR←ADDR+4, go FETCH.
  - STALL: hold everything.
- DROP (stale request outstanding):
  - REDIRECT: PC←REDIRECT_PC (latest wins), FD flushed, stay DROP unless READY.
  - READY: response discarded, ADDR←PC (or REDIRECT_PC if REDIRECT same cycle), go FETCH.
  - While in DROP and !STALL, FD shows bubble. STALL holds FD (already NOP).
- REDIRECT has priority over STALL in every state.
- Arithmetic: PC+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0.

## Timing
- Hit latency: READY in cycle N → FD_IR/FD_VALID valid after edge ending cycle N. Next request is issued in cycle N+1.
- Continuous hits with no stall: one instruction per cycle, consecutive PCs.
- Miss of k cycles: k bubbles (FD_VALID=0) while !STALL.
- Redirect: first instruction from the target reaches FD no earlier than 1 cycle after REDIRECT (on a hit), or after the stale response + new fetch latency in DROP.
- No combinational path from inputs to FD_* outputs. I_MEM_REQ/ADDR depend only on registered state.

## Test plan
- Reset, READY tied 1, no stall → FD_PC sequence 0,4,8,12 on consecutive cycles, FD_VALID=1 from the 2nd cycle after RSTn rises; FD_IR=I_MEM_DI of each address.
- Miss: READY low 3 cycles at ADDR=0x10 → ADDR held at 0x10, 3 bubbles with FD_IR=0x00000013, then FD_PC=0x10.
- STALL asserted on the cycle READY returns 0xDEADBEEF for 0x20 → HOLD, REQ=0, FD unchanged. STALL drops → FD_IR=0xDEADBEEF, FD_PC=0x20, next ADDR=0x24.
- REDIRECT to 0x100 while 0x30 miss is outstanding → ADDR stays 0x30 until READY, that word is not loaded. Next request is at 0x100, FD_PC=0x100.
- REDIRECT and STALL together in HOLD → BUF discarded, FD_VALID=0, ADDR=REDIRECT_PC; PC=0xFFFFFFFC fetch → next ADDR=0x0. RSTn low mid-miss → all outputs at reset values next cycle.
